// File: rtl/cnt_chk_pkg.sv
// Shared definitions for the counter sequence checker.
// Holds the FSM state encoding, the state width, and a helper that sizes
// the good/bad run counters from their terminal counts.
package cnt_chk_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 2'd0,
        ST_ACQ    = 2'd1,
        ST_LOCKED = 2'd2,
        ST_SLIP   = 2'd3
    } state_t;

    // Bits needed to hold a run count of 0..n (at least one bit).
    function automatic int run_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-low reset, clears q
//   inc  - increment request, ignored once q is all-ones
//   clr  - synchronous clear, wins over inc
//   q    - current count
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/cnt_seq_checker.sv
// Receive-side checker for the counter bus.
// Each accepted sample is compared with the previous sample +1 (or -1),
// modulo 2^WIDTH. A small FSM tracks acquisition / lock / slip, and
// saturating counters record sequence errors and wraps seen while locked.
// Ports:
//   clk       - clock, rising edge
//   rst       - asynchronous active-low reset
//   ena       - block enable; 0 ignores samples and holds state
//   cnt_in    - counter value under check
//   cnt_vld   - cnt_in valid this cycle
//   dir_down  - 0 expects +1 steps, 1 expects -1 steps
//   clr       - synchronous clear of counters and FSM (last_val holds)
//   locked    - FSM is in LOCKED or SLIP
//   err_pulse - one-cycle pulse per counted error
//   err_cnt   - saturating error count
//   wrap_cnt  - saturating wrap count
//   last_val  - last accepted sample
//   state_o   - FSM state, for debug
module cnt_seq_checker
    import cnt_chk_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int LOCK_N   = 4,
    parameter int UNLOCK_N = 2,
    parameter int ERRW     = 8,
    parameter int WRAPW    = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ena,
    input  logic [WIDTH-1:0]   cnt_in,
    input  logic               cnt_vld,
    input  logic               dir_down,
    input  logic               clr,
    output logic               locked,
    output logic               err_pulse,
    output logic [ERRW-1:0]    err_cnt,
    output logic [WRAPW-1:0]   wrap_cnt,
    output logic [WIDTH-1:0]   last_val,
    output logic [STATE_W-1:0] state_o
);

    localparam int GOOD_W = run_w(LOCK_N);
    localparam int BAD_W  = run_w(UNLOCK_N);

    // Run-count values that, after one more step, reach the threshold.
    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_N - 1);
    localparam logic [BAD_W-1:0]  BAD_LAST  = BAD_W'(UNLOCK_N - 1);

    state_t             state;
    logic [GOOD_W-1:0]  good;
    logic [BAD_W-1:0]   bad;

    logic               accept;
    logic [WIDTH-1:0]   exp_val;
    logic               match;
    logic               wrap_hit;
    logic               in_lock;
    logic               err_inc;
    logic               wrap_inc;

    always_comb begin
        accept   = ena & cnt_vld & ~clr;
        exp_val  = dir_down ? (last_val - 1'b1) : (last_val + 1'b1);
        match    = (cnt_in == exp_val);
        wrap_hit = dir_down ? (cnt_in == '1) : (cnt_in == '0);
        in_lock  = (state == ST_LOCKED) || (state == ST_SLIP);
        err_inc  = accept & ~match & in_lock;
        wrap_inc = accept & match & in_lock & wrap_hit;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            good      <= '0;
            bad       <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            last_val  <= '0;
        end else if (clr) begin
            state     <= ST_IDLE;
            good      <= '0;
            bad       <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
        end else begin
            err_pulse <= err_inc;
            if (accept) begin
                last_val <= cnt_in;
                case (state)
                    ST_IDLE: begin
                        state <= ST_ACQ;
                        good  <= '0;
                        bad   <= '0;
                    end
                    ST_ACQ: begin
                        if (!match) begin
                            good <= '0;
                        end else if (good == GOOD_LAST) begin
                            state  <= ST_LOCKED;
                            locked <= 1'b1;
                            good   <= '0;
                        end else begin
                            good <= good + 1'b1;
                        end
                    end
                    ST_LOCKED: begin
                        // With UNLOCK_N=1 the first bad step already
                        // reaches the threshold, so SLIP is skipped.
                        if (!match) begin
                            if (UNLOCK_N == 1) begin
                                state  <= ST_ACQ;
                                locked <= 1'b0;
                                good   <= '0;
                                bad    <= '0;
                            end else begin
                                state <= ST_SLIP;
                                bad   <= BAD_W'(1);
                            end
                        end
                    end
                    ST_SLIP: begin
                        if (match) begin
                            state <= ST_LOCKED;
                            bad   <= '0;
                        end else if (bad == BAD_LAST) begin
                            state  <= ST_ACQ;
                            locked <= 1'b0;
                            good   <= '0;
                            bad    <= '0;
                        end else begin
                            bad <= bad + 1'b1;
                        end
                    end
                    default: begin
                        state  <= ST_IDLE;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign state_o = state;

    sat_counter #(.W(ERRW)) u_err_cnt (
        .clk (clk),
        .rst (rst),
        .inc (err_inc),
        .clr (clr),
        .q   (err_cnt)
    );

    sat_counter #(.W(WRAPW)) u_wrap_cnt (
        .clk (clk),
        .rst (rst),
        .inc (wrap_inc),
        .clr (clr),
        .q   (wrap_cnt)
    );

endmodule

// File: tb/tb_cnt_seq_checker.sv
// Directed bench for cnt_seq_checker: a default-width instance plus an
// ERRW=2 instance sharing the same stimulus for the saturation case.
module tb_cnt_seq_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic [7:0] cnt_in;
    logic       cnt_vld;
    logic       dir_down;
    logic       clr;

    logic       locked, err_pulse;
    logic [7:0] err_cnt, wrap_cnt, last_val;
    logic [1:0] state_o;

    logic       locked2, err_pulse2;
    logic [1:0] err_cnt2;
    logic [7:0] wrap_cnt2, last_val2;
    logic [1:0] state_o2;

    int n_checks = 0;
    int n_errors = 0;
    int pulses   = 0;
    int pulses2  = 0;

    always #5 clk = ~clk;

    cnt_seq_checker #(.WIDTH(8), .LOCK_N(4), .UNLOCK_N(2), .ERRW(8), .WRAPW(8)) dut (
        .clk(clk), .rst(rst), .ena(ena), .cnt_in(cnt_in), .cnt_vld(cnt_vld),
        .dir_down(dir_down), .clr(clr), .locked(locked), .err_pulse(err_pulse),
        .err_cnt(err_cnt), .wrap_cnt(wrap_cnt), .last_val(last_val), .state_o(state_o)
    );

    cnt_seq_checker #(.WIDTH(8), .LOCK_N(4), .UNLOCK_N(2), .ERRW(2), .WRAPW(8)) dut2 (
        .clk(clk), .rst(rst), .ena(ena), .cnt_in(cnt_in), .cnt_vld(cnt_vld),
        .dir_down(dir_down), .clr(clr), .locked(locked2), .err_pulse(err_pulse2),
        .err_cnt(err_cnt2), .wrap_cnt(wrap_cnt2), .last_val(last_val2), .state_o(state_o2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tally();
        if (err_pulse)  pulses++;
        if (err_pulse2) pulses2++;
    endtask

    task automatic smp(input logic [7:0] v);
        @(negedge clk);
        cnt_in  = v;
        cnt_vld = 1'b1;
        @(posedge clk);
        #1;
        cnt_vld = 1'b0;
        tally();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            cnt_vld = 1'b0;
            @(posedge clk);
            #1;
            tally();
        end
    endtask

    task automatic do_clr();
        @(negedge clk);
        clr     = 1'b1;
        cnt_vld = 1'b0;
        @(posedge clk);
        #1;
        clr = 1'b0;
    endtask

    initial begin
        rst = 1'b0; ena = 1'b1; cnt_in = '0; cnt_vld = 1'b0; dir_down = 1'b0; clr = 1'b0;

        // 1. Reset with random inputs, then quiet period
        repeat (4) begin
            @(negedge clk);
            cnt_in   = 8'($urandom);
            cnt_vld  = 1'($urandom);
            dir_down = 1'($urandom);
            clr      = 1'($urandom);
            ena      = 1'($urandom);
        end
        #1;
        check("rst_locked",   locked,    0);
        check("rst_pulse",    err_pulse, 0);
        check("rst_err_cnt",  err_cnt,   0);
        check("rst_wrap_cnt", wrap_cnt,  0);
        check("rst_last_val", last_val,  0);
        check("rst_state",    state_o,   0);
        @(negedge clk);
        ena = 1'b1; cnt_vld = 1'b0; dir_down = 1'b0; clr = 1'b0;
        rst = 1'b1;
        idle(10);
        check("quiet_state", state_o,  0);
        check("quiet_last",  last_val, 0);

        // 2. Lock on an up stream
        smp(8'h10);
        check("acq_state", state_o, 1);
        smp(8'h11); smp(8'h12); smp(8'h13);
        check("acq_not_locked", locked, 0);
        smp(8'h14);
        check("lock_locked", locked,  1);
        check("lock_state",  state_o, 2);
        for (int i = 8'h15; i <= 8'h20; i++) smp(8'(i));
        check("lock_err_cnt", err_cnt,  0);
        check("lock_last",    last_val, 8'h20);
        check("lock_state2",  state_o,  2);

        // 3. Wrap then a single slip
        do_clr();
        for (int i = 8'hF8; i <= 8'hFC; i++) smp(8'(i));
        check("wrap_pre_lock", locked, 1);
        smp(8'hFD); smp(8'hFE); smp(8'hFF);
        check("wrap_before", wrap_cnt, 0);
        smp(8'h00);
        check("wrap_after00", wrap_cnt, 1);
        smp(8'h01);
        check("wrap_after01", wrap_cnt, 1);
        pulses = 0;
        smp(8'h50);
        check("slip_state",  state_o,   3);
        check("slip_pulse",  err_pulse, 1);
        check("slip_errcnt", err_cnt,   1);
        check("slip_locked", locked,    1);
        smp(8'h51);
        check("relock_state", state_o,   2);
        check("relock_pulse", err_pulse, 0);
        check("relock_lock",  locked,    1);
        check("slip_pulses",  pulses,    1);

        // 4. Loss of lock and re-acquisition
        do_clr();
        for (int i = 8'h30; i <= 8'h34; i++) smp(8'(i));
        check("lol_pre_lock", locked, 1);
        smp(8'h80); smp(8'h33);
        check("lol_errcnt", err_cnt, 2);
        check("lol_state",  state_o, 1);
        check("lol_locked", locked,  0);
        smp(8'h34); smp(8'h35); smp(8'h36);
        check("lol_acq3", locked, 0);
        smp(8'h37);
        check("lol_relock", locked,  1);
        check("lol_state2", state_o, 2);

        // 5a. Down stream with 00 -> FF wrap
        do_clr();
        dir_down = 1'b1;
        smp(8'h04); smp(8'h03); smp(8'h02); smp(8'h01);
        check("dn_not_locked", locked, 0);
        smp(8'h00);
        check("dn_locked", locked,   1);
        check("dn_wrap0",  wrap_cnt, 0);
        smp(8'hFF);
        check("dn_wrap1",  wrap_cnt, 1);
        check("dn_errcnt", err_cnt,  0);

        // 5b. Five errors: 8-bit count reaches 5, 2-bit count saturates at 3
        do_clr();
        dir_down = 1'b0;
        for (int i = 8'h40; i <= 8'h44; i++) smp(8'(i));
        pulses = 0; pulses2 = 0;
        for (int i = 0; i < 5; i++) begin
            smp(8'(8'h60 + i * 16));
            smp(8'(8'h61 + i * 16));
        end
        check("sat_err8",    err_cnt,  5);
        check("sat_err2",    err_cnt2, 3);
        check("sat_pulses2", pulses2,  5);
        check("sat_pulses",  pulses,   5);
        check("sat_state",   state_o,  2);

        // 6a. clr together with a valid sample
        @(negedge clk);
        clr = 1'b1; cnt_vld = 1'b1; cnt_in = 8'h99;
        @(posedge clk);
        #1;
        clr = 1'b0; cnt_vld = 1'b0;
        check("clr_state",  state_o,   0);
        check("clr_err",    err_cnt,   0);
        check("clr_err2",   err_cnt2,  0);
        check("clr_wrap",   wrap_cnt,  0);
        check("clr_last",   last_val,  8'hA1);
        check("clr_locked", locked,    0);
        check("clr_pulse",  err_pulse, 0);

        // 6b. ena=0 ignores samples
        ena = 1'b0;
        smp(8'hA2); smp(8'h17);
        check("ena0_state", state_o,  0);
        check("ena0_last",  last_val, 8'hA1);
        ena = 1'b1;
        smp(8'h10);
        check("ena1_state", state_o,  1);
        check("ena1_last",  last_val, 8'h10);

        // 7. Asynchronous reset mid-operation
        smp(8'h11); smp(8'h12); smp(8'h13); smp(8'h14);
        check("mid_pre_lock", locked, 1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rst_lock",  locked,   0);
        check("mid_rst_state", state_o,  0);
        check("mid_rst_last",  last_val, 0);
        @(negedge clk);
        rst = 1'b1;
        smp(8'h55);
        check("post_rst_state", state_o,  1);
        check("post_rst_last",  last_val, 8'h55);
        check("post_rst_err",   err_cnt,  0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
